// File: rtl/hash_stream_ctrl_if.sv
// hash_stream_ctrl_if: input stream, hash core and output stream signals of hash_stream_ctrl
interface hash_stream_ctrl_if #(
  parameter int IN_W = 8,
  parameter int DIGEST_W = 160,
  parameter int OUT_W = 32
);
  logic i_valid;
  logic i_ready;
  logic [IN_W-1:0] i_data;
  logic core_start;
  logic [511:0] core_block;
  logic core_done;
  logic [DIGEST_W-1:0] core_digest;
  logic o_valid;
  logic o_ready;
  logic [OUT_W-1:0] o_data;
  logic o_last;
  logic busy;
  modport master (
    input i_valid, i_data, core_done, core_digest, o_ready,
    output i_ready, core_start, core_block, o_valid, o_data, o_last, busy
  );
  modport slave (
    output i_valid, i_data, core_done, core_digest, o_ready,
    input i_ready, core_start, core_block, o_valid, o_data, o_last, busy
  );
endinterface

// File: rtl/hash_stream_ctrl.sv
// hash_stream_ctrl: packs input beats into 512-bit blocks, starts the hash core and streams out its digest; define OUT_BSWAP_EN to byte-reverse each output word
module hash_stream_ctrl #(
  parameter int IN_W = 8,
  parameter int DIGEST_W = 160,
  parameter int OUT_W = 32
) (
  input logic clk,
  input logic rst_n,
  hash_stream_ctrl_if.master bus
);
  localparam int BEATS = 512 / IN_W;
  localparam int WORDS = DIGEST_W / OUT_W;
  localparam int BW = $clog2(BEATS);
  localparam int WW = WORDS > 1 ? $clog2(WORDS) : 1;
  localparam logic [1:0] FILL = 2'd0, START = 2'd1, WAIT = 2'd2, DRAIN = 2'd3;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [WW-1:0] LAST_WORD = WW'(WORDS - 1);
  logic [1:0] state;
  logic [BW-1:0] beat_cnt;
  logic [WW-1:0] word_cnt;
  logic [511:0] blk;
  logic [DIGEST_W-1:0] sreg;
  logic [OUT_W-1:0] top, ow;
  logic in_hs, out_hs;
  assign in_hs = state == FILL && bus.i_valid;
  assign out_hs = state == DRAIN && bus.o_ready;
  assign top = sreg[DIGEST_W-1 -: OUT_W];
  assign bus.i_ready = state == FILL;
  assign bus.core_start = state == START;
  assign bus.core_block = blk;
  assign bus.o_valid = state == DRAIN;
  assign bus.o_data = ow;
  assign bus.o_last = state == DRAIN && word_cnt == LAST_WORD;
  assign bus.busy = state != FILL || beat_cnt != '0;
  // FSM and beat/word counters; core_done outside WAIT falls through untouched
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= FILL;
      beat_cnt <= '0;
      word_cnt <= '0;
    end else
      case (state)
        FILL: if (in_hs) begin
          beat_cnt <= beat_cnt == LAST_BEAT ? '0 : beat_cnt + 1'b1;
          state <= beat_cnt == LAST_BEAT ? START : FILL;
        end
        START: state <= WAIT;
        WAIT: if (bus.core_done) begin
          word_cnt <= '0;
          state <= DRAIN;
        end
        default: if (out_hs) begin
          word_cnt <= word_cnt + 1'b1;
          state <= word_cnt == LAST_WORD ? FILL : DRAIN;
        end
      endcase
  // block assembly (first beat at the top) and digest shift register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      blk <= '0;
      sreg <= '0;
    end else begin
      if (in_hs) blk[(BEATS - 1 - int'(beat_cnt)) * IN_W +: IN_W] <= bus.i_data;
      if (state == WAIT && bus.core_done) sreg <= bus.core_digest;
      else if (out_hs) sreg <= sreg << OUT_W;
    end
  // output word, optionally byte-reversed for little-endian consumers
  always_comb begin
    ow = top;
`ifdef OUT_BSWAP_EN
    for (int b = 0; b < OUT_W / 8; b++) ow[8*b +: 8] = top[OUT_W-8-8*b +: 8];
`endif
  end
endmodule

// File: tb/tb_hash_stream_ctrl.sv
// tb_hash_stream_ctrl: directed checks of block fill, digest drain, backpressure, stray core_done and reset
module tb_hash_stream_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int ncmp = 0;
  int nfail = 0;
  logic [511:0] blk_a;
  localparam logic [159:0] D = 160'h0123456789ABCDEF0011223344556677DEADBEEF;
  localparam logic [159:0] D2 = 160'hFFEEDDCCBBAA99887766554433221100CAFEF00D;
  localparam logic [159:0] JUNK = 160'h5555AAAA5555AAAA5555AAAA5555AAAA5555AAAA;

  hash_stream_ctrl_if #(.IN_W(8), .DIGEST_W(160), .OUT_W(32)) b8();
  hash_stream_ctrl_if #(.IN_W(32), .DIGEST_W(160), .OUT_W(32)) b32();
  hash_stream_ctrl #(.IN_W(8), .DIGEST_W(160), .OUT_W(32)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8.master));
  hash_stream_ctrl #(.IN_W(32), .DIGEST_W(160), .OUT_W(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32.master));

  always #5 clk = ~clk;

  function automatic logic [31:0] ew(input logic [159:0] d, input int i);
    logic [31:0] w;
    w = d[159-32*i -: 32];
`ifdef OUT_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic test_reset();
    @(negedge clk);
    ncmp++; if (b8.i_ready !== 1'b1) begin nfail++; $display("FAIL rst_i_ready: got %b want 1", b8.i_ready); end
    ncmp++; if (b8.core_start !== 1'b0) begin nfail++; $display("FAIL rst_core_start: got %b want 0", b8.core_start); end
    ncmp++; if (b8.core_block !== 512'd0) begin nfail++; $display("FAIL rst_core_block: got %h want 0", b8.core_block); end
    ncmp++; if (b8.o_valid !== 1'b0) begin nfail++; $display("FAIL rst_o_valid: got %b want 0", b8.o_valid); end
    ncmp++; if (b8.o_data !== 32'd0) begin nfail++; $display("FAIL rst_o_data: got %h want 0", b8.o_data); end
    ncmp++; if (b8.o_last !== 1'b0) begin nfail++; $display("FAIL rst_o_last: got %b want 0", b8.o_last); end
    ncmp++; if (b8.busy !== 1'b0) begin nfail++; $display("FAIL rst_busy: got %b want 0", b8.busy); end
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    logic [511:0] exp;
    int pulses = 0;
    for (int k = 0; k < 64; k++) begin
      exp[511-8*k -: 8] = 8'(k);
      @(negedge clk);
      if (b8.core_start === 1'b1) pulses++;
      if (k == 1) begin
        ncmp++; if (b8.busy !== 1'b1) begin nfail++; $display("FAIL fill_busy: got %b want 1", b8.busy); end
        ncmp++; if (b8.i_ready !== 1'b1) begin nfail++; $display("FAIL fill_i_ready: got %b want 1", b8.i_ready); end
      end
      b8.i_valid = 1'b1;
      b8.i_data = 8'(k);
    end
    @(negedge clk);
    b8.i_valid = 1'b0;
    ncmp++; if (b8.core_start !== 1'b1) begin nfail++; $display("FAIL fill_start: got %b want 1", b8.core_start); end
    ncmp++; if (b8.i_ready !== 1'b0) begin nfail++; $display("FAIL fill_start_i_ready: got %b want 0", b8.i_ready); end
    ncmp++; if (b8.core_block !== exp) begin nfail++; $display("FAIL fill_block: got %h want %h", b8.core_block, exp); end
    if (b8.core_start === 1'b1) pulses++;
    repeat (3) begin
      @(negedge clk);
      if (b8.core_start === 1'b1) pulses++;
    end
    ncmp++; if (pulses != 1) begin nfail++; $display("FAIL fill_pulses: got %0d want 1", pulses); end
    ncmp++; if (b8.busy !== 1'b1) begin nfail++; $display("FAIL wait_busy: got %b want 1", b8.busy); end
  endtask

  task automatic test_drain();
    b8.core_digest = D;
    b8.core_done = 1'b1;
    b8.o_ready = 1'b1;
    @(negedge clk);
    b8.core_done = 1'b0;
    for (int w = 0; w < 5; w++) begin
      ncmp++; if (b8.o_valid !== 1'b1) begin nfail++; $display("FAIL drain_valid[%0d]: got %b want 1", w, b8.o_valid); end
      ncmp++; if (b8.o_data !== ew(D, w)) begin nfail++; $display("FAIL drain_data[%0d]: got %h want %h", w, b8.o_data, ew(D, w)); end
      ncmp++; if (b8.o_last !== (w == 4)) begin nfail++; $display("FAIL drain_last[%0d]: got %b want %b", w, b8.o_last, w == 4); end
      @(negedge clk);
    end
    ncmp++; if (b8.o_valid !== 1'b0) begin nfail++; $display("FAIL drain_end_valid: got %b want 0", b8.o_valid); end
    ncmp++; if (b8.i_ready !== 1'b1) begin nfail++; $display("FAIL drain_end_i_ready: got %b want 1", b8.i_ready); end
    ncmp++; if (b8.busy !== 1'b0) begin nfail++; $display("FAIL drain_end_busy: got %b want 0", b8.busy); end
  endtask

  task automatic test_spurious_done();
    b8.o_ready = 1'b0;
    b8.core_digest = JUNK;
    b8.core_done = 1'b1;
    @(negedge clk);
    b8.core_done = 1'b0;
    for (int k = 0; k < 64; k++) begin
      blk_a[511-8*k -: 8] = 8'(8'hA0 ^ k);
      b8.i_valid = 1'b1;
      b8.i_data = 8'(8'hA0 ^ k);
      @(negedge clk);
    end
    b8.i_valid = 1'b0;
    ncmp++; if (b8.core_start !== 1'b1) begin nfail++; $display("FAIL spur_start: got %b want 1", b8.core_start); end
    b8.core_digest = ~JUNK;
    b8.core_done = 1'b1;
    @(negedge clk);
    b8.core_done = 1'b0;
    repeat (2) begin
      ncmp++; if (b8.o_valid !== 1'b0) begin nfail++; $display("FAIL spur_valid: got %b want 0", b8.o_valid); end
      @(negedge clk);
    end
    b8.core_digest = D;
    b8.core_done = 1'b1;
    b8.o_ready = 1'b1;
    @(negedge clk);
    b8.core_done = 1'b0;
    b8.core_digest = JUNK;
    ncmp++; if (b8.o_valid !== 1'b1) begin nfail++; $display("FAIL spur_real_valid: got %b want 1", b8.o_valid); end
    ncmp++; if (b8.o_data !== ew(D, 0)) begin nfail++; $display("FAIL spur_word0: got %h want %h", b8.o_data, ew(D, 0)); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    b8.o_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      ncmp++; if (b8.o_data !== ew(D, 1)) begin nfail++; $display("FAIL bp_data[%0d]: got %h want %h", c, b8.o_data, ew(D, 1)); end
      ncmp++; if (b8.o_valid !== 1'b1 || b8.o_last !== 1'b0 || b8.i_ready !== 1'b0) begin
        nfail++; $display("FAIL bp_ctl[%0d]: got v%b l%b r%b want v1 l0 r0", c, b8.o_valid, b8.o_last, b8.i_ready);
      end
      b8.i_valid = ~b8.i_valid;
      b8.i_data = 8'($urandom);
    end
    b8.i_valid = 1'b0;
    b8.o_ready = 1'b1;
    for (int w = 1; w < 5; w++) begin
      ncmp++; if (b8.o_data !== ew(D, w)) begin nfail++; $display("FAIL bp_resume[%0d]: got %h want %h", w, b8.o_data, ew(D, w)); end
      ncmp++; if (b8.o_last !== (w == 4)) begin nfail++; $display("FAIL bp_last[%0d]: got %b want %b", w, b8.o_last, w == 4); end
      @(negedge clk);
    end
    b8.o_ready = 1'b0;
    ncmp++; if (b8.i_ready !== 1'b1) begin nfail++; $display("FAIL bp_end_i_ready: got %b want 1", b8.i_ready); end
    ncmp++; if (b8.core_block !== blk_a) begin nfail++; $display("FAIL bp_block_hold: got %h want %h", b8.core_block, blk_a); end
  endtask

  task automatic test_reset_mid_drain();
    logic [511:0] exp;
    for (int k = 0; k < 16; k++) begin
      exp[511-32*k -: 32] = 32'hC0DE0000 + 32'(k);
      b32.i_valid = 1'b1;
      b32.i_data = 32'hC0DE0000 + 32'(k);
      @(negedge clk);
    end
    b32.i_valid = 1'b0;
    ncmp++; if (b32.core_block !== exp) begin nfail++; $display("FAIL w32_old_block: got %h want %h", b32.core_block, exp); end
    @(negedge clk);
    b32.core_digest = D2;
    b32.core_done = 1'b1;
    b32.o_ready = 1'b1;
    @(negedge clk);
    b32.core_done = 1'b0;
    repeat (3) @(negedge clk);
    ncmp++; if (b32.o_data !== ew(D2, 3)) begin nfail++; $display("FAIL w32_word3: got %h want %h", b32.o_data, ew(D2, 3)); end
    b32.o_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    ncmp++; if (b32.i_ready !== 1'b1 || b32.core_start !== 1'b0 || b32.o_valid !== 1'b0 || b32.o_last !== 1'b0 || b32.busy !== 1'b0) begin
      nfail++; $display("FAIL w32_rst_ctl: got r%b s%b v%b l%b b%b want r1 s0 v0 l0 b0", b32.i_ready, b32.core_start, b32.o_valid, b32.o_last, b32.busy);
    end
    ncmp++; if (b32.o_data !== 32'd0) begin nfail++; $display("FAIL w32_rst_data: got %h want 0", b32.o_data); end
    ncmp++; if (b32.core_block !== 512'd0) begin nfail++; $display("FAIL w32_rst_block: got %h want 0", b32.core_block); end
    @(negedge clk);
    rst_n = 1'b1;
    exp = '0;
    for (int k = 0; k < 16; k++) begin
      exp[511-32*k -: 32] = 32'h13570000 + 32'(k * 3);
      b32.i_valid = 1'b1;
      b32.i_data = 32'h13570000 + 32'(k * 3);
      @(negedge clk);
      if (k == 0) begin
        ncmp++; if (b32.core_block !== exp) begin nfail++; $display("FAIL w32_first_beat: got %h want %h", b32.core_block, exp); end
      end
    end
    b32.i_valid = 1'b0;
    ncmp++; if (b32.core_start !== 1'b1) begin nfail++; $display("FAIL w32_start: got %b want 1", b32.core_start); end
    ncmp++; if (b32.core_block !== exp) begin nfail++; $display("FAIL w32_new_block: got %h want %h", b32.core_block, exp); end
    @(negedge clk);
    b32.core_digest = D;
    b32.core_done = 1'b1;
    b32.o_ready = 1'b1;
    @(negedge clk);
    b32.core_done = 1'b0;
    for (int w = 0; w < 5; w++) begin
      ncmp++; if (b32.o_data !== ew(D, w) || b32.o_last !== (w == 4)) begin
        nfail++; $display("FAIL w32_drain[%0d]: got %h last %b want %h last %b", w, b32.o_data, b32.o_last, ew(D, w), w == 4);
      end
      @(negedge clk);
    end
    ncmp++; if (b32.o_valid !== 1'b0 || b32.busy !== 1'b0) begin nfail++; $display("FAIL w32_end: got v%b b%b want v0 b0", b32.o_valid, b32.busy); end
  endtask

  initial begin
    b8.i_valid = 1'b0; b8.i_data = '0; b8.core_done = 1'b0; b8.core_digest = '0; b8.o_ready = 1'b0;
    b32.i_valid = 1'b0; b32.i_data = '0; b32.core_done = 1'b0; b32.core_digest = '0; b32.o_ready = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_spurious_done();
    test_backpressure();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
